mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT, 255, maximum cycles an accepted transaction may spend in REQ plus RESP before it is aborted; RR, 1, 1 selects round-robin arbitration and 0 selects fixed LSU priority.
REQ-002 Ports SHALL be: clk  in  1  clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-003 IFU request ports SHALL be: ifu_req_valid  in  1  fetch request; ifu_req_ready  out  1  grant/accept; ifu_addr  in  32  fetch address.
REQ-004 IFU response ports SHALL be: ifu_resp_valid  out  1  one-cycle response; ifu_rdata  out  32  fetched word; ifu_err  out  1  timeout abort.
REQ-005 LSU request ports SHALL be: lsu_req_valid  in  1; lsu_req_ready  out  1; lsu_wen  in  1  (1 = store); lsu_addr  in  32; lsu_wdata  in  32; lsu_wmask  in  4  byte enables.
REQ-006 LSU response ports SHALL be: lsu_resp_valid  out  1; lsu_rdata  out  32; lsu_err  out  1.
REQ-007 Memory request ports SHALL be: mem_req_valid  out  1; mem_req_ready  in  1; mem_wen  out  1; mem_addr  out  32; mem_wdata  out  32; mem_wmask  out  4.
REQ-008 Memory response ports SHALL be: mem_resp_valid  in  1  (stores also acknowledge); mem_rdata  in  32; busy  out  1  (state != IDLE).

Function
REQ-009 FSM SHALL have exactly three states, IDLE, REQ and RESP, with at most one transaction outstanding.
REQ-010 In IDLE, ready SHALL be driven combinationally high to at most one requester, the winner; the winner's fields are latched on the clk edge on which valid && ready holds, and the state moves to REQ.
REQ-011 With RR=1 and both requesting, the requester not granted last SHALL win; the last-grant register resets to IFU, so LSU wins the first tie.
REQ-012 With RR=0, LSU SHALL win every tie.
REQ-013 A single requester SHALL be granted in the same cycle it asserts valid while the FSM is in IDLE.
REQ-014 In REQ, mem_req_valid SHALL be 1 with the latched wen, addr, wdata and wmask; IFU transactions drive wen=0 and wmask=0.
REQ-015 REQ SHALL move to RESP on mem_req_valid && mem_req_ready.
REQ-016 In RESP, when mem_resp_valid=1, the owner's resp_valid SHALL be 1 combinationally in that same cycle, with rdata = mem_rdata, err = 0, and the state moves to IDLE.
REQ-017 The non-owner's resp_valid SHALL remain 0 in RESP.
REQ-018 Minimum latency SHALL be: grant at cycle T, mem_req_valid at T+1, resp_valid at T+2 (memory ready at T+1, response at T+2); the next grant is possible at T+3.
REQ-019 An 8-bit-minimum timeout counter SHALL clear on grant and increment on every cycle in REQ or RESP.
REQ-020 When the timeout counter equals TIMEOUT, the FSM SHALL go to IDLE next cycle and give the owner resp_valid=1, err=1, rdata=0 in that same cycle.
REQ-021 If mem_req_ready or mem_resp_valid coincides with the timeout cycle, the normal handshake SHALL take precedence over the timeout.
REQ-022 mem_resp_valid arriving in IDLE or REQ SHALL be ignored.
REQ-023 Requester fields SHALL be sampled only on the grant edge; later changes do not affect the transaction in flight.
REQ-024 Requests arriving while busy=1 SHALL be held off with ready=0; requesters keep valid asserted.
REQ-025 rdata outputs SHALL be 0 whenever the corresponding resp_valid is 0.

Reset
REQ-026 On rst, the FSM SHALL enter IDLE, the last-grant register set to IFU, the timeout counter and all latched fields clear to 0, and the owner register clear.
REQ-027 While rst is high, all outputs SHALL be 0 and no grant is issued.
REQ-028 Asserting rst mid-transaction SHALL abort it silently, with no resp_valid and no err.

Structure
REQ-029 Shared package npc_mem_pkg SHALL hold the FSM state encoding, the owner encoding (OWN_IFU=0, OWN_LSU=1) and the TIMEOUT default.
REQ-030 Two-way round-robin selection SHALL live in sub-module rr_arb2 (inputs req[1:0], last, rr_en; output one-hot gnt[1:0]), instantiated once.

Verification
REQ-031 The bench SHALL cover: IFU-only read of 0x8000_0000, memory ready at once, rdata 0x0000_0413 at T+2 -> ifu_resp_valid high at T+2 with ifu_rdata=0x0000_0413, ifu_err=0, busy low at T+3.
REQ-032 The bench SHALL cover: IFU and LSU valid together after reset, RR=1 -> LSU granted first, IFU granted on the first IDLE cycle after LSU's response; repeated ties alternate grants.
REQ-033 The bench SHALL cover: RR=0 with both requesters held valid for 4 transactions -> all 4 grants to LSU, IFU ready never high.
REQ-034 The bench SHALL cover: LSU store of addr 0x8000_0010, wdata 0xDEAD_BEEF, wmask 4'b0011, memory ready delayed 3 cycles -> mem_wen=1 and fields stable for all REQ cycles; lsu_resp_valid on the acknowledge.
REQ-035 The bench SHALL cover: TIMEOUT=4, memory never responds -> resp_valid=1, err=1, rdata=0 on the 4th busy cycle; a stray mem_resp_valid afterwards is ignored.
REQ-036 The bench SHALL cover: rst pulsed during RESP -> no resp_valid, busy=0, and the next tie goes to LSU.

Source files
------------

// File: rtl/npc_mem_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM state, transaction owner
// and the latched request bundle.
package npc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam int TIMEOUT_DEFAULT = 255;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: bit 0 = IFU, bit 1 = LSU. On a tie the side not granted
// last wins when rr_en is set, otherwise the LSU always wins.
module rr_arb2
  import npc_mem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_en && last == OWN_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch
// and load/store, with a per-transaction timeout that aborts with err=1.
module mem_arbiter
  import npc_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter bit RR      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int            CW      = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  // cnt holds the busy cycles already completed, so the TIMEOUT-th busy cycle
  // is the one where cnt reaches TIMEOUT-1.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t       state, state_nxt;
  owner_t       owner, last_gnt;
  mem_req_t     req_q;
  logic [CW-1:0] cnt;

  logic [1:0] arb_req, gnt;
  logic       grant, to_hit, resp_fire, abort, done;

  assign arb_req = (state == ST_IDLE && !rst) ? {lsu_req_valid, ifu_req_valid} : 2'b00;
  assign grant   = |gnt;

  rr_arb2 u_arb (
    .req   (arb_req),
    .last  (last_gnt),
    .rr_en (RR),
    .gnt   (gnt)
  );

  assign to_hit    = (state != ST_IDLE) && (cnt >= TO_LAST);
  assign resp_fire = (state == ST_RESP) && mem_resp_valid;
  // A handshake landing on the timeout cycle wins over the abort.
  assign abort     = to_hit && !resp_fire && !(state == ST_REQ && mem_req_ready);
  assign done      = resp_fire || abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant) state_nxt = ST_REQ;
      ST_REQ: begin
        if (mem_req_ready) state_nxt = ST_RESP;
        else if (abort)    state_nxt = ST_IDLE;
      end
      ST_RESP: if (done)  state_nxt = ST_IDLE;
      default:            state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready  = gnt[0];
    lsu_req_ready  = gnt[1];
    busy           = (state != ST_IDLE);
    mem_req_valid  = (state == ST_REQ);
    mem_wen        = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    ifu_err        = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    lsu_err        = 1'b0;
    if (state == ST_REQ) begin
      mem_wen   = req_q.wen;
      mem_addr  = req_q.addr;
      mem_wdata = req_q.wdata;
      mem_wmask = req_q.wmask;
    end
    if (done) begin
      if (owner == OWN_LSU) begin
        lsu_resp_valid = 1'b1;
        lsu_rdata      = resp_fire ? mem_rdata : '0;
        lsu_err        = abort;
      end else begin
        ifu_resp_valid = 1'b1;
        ifu_rdata      = resp_fire ? mem_rdata : '0;
        ifu_err        = abort;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= OWN_IFU;
      last_gnt <= OWN_IFU;
      req_q    <= '0;
      cnt      <= '0;
    end else if (grant) begin
      owner    <= gnt[1] ? OWN_LSU : OWN_IFU;
      last_gnt <= gnt[1] ? OWN_LSU : OWN_IFU;
      cnt      <= '0;
      req_q    <= gnt[1] ? '{wen: lsu_wen, addr: lsu_addr, wdata: lsu_wdata, wmask: lsu_wmask}
                         : '{wen: 1'b0, addr: ifu_addr, wdata: 32'h0, wmask: 4'h0};
    end else if (state != ST_IDLE && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
